// File: rtl/xdma_desc_byp_arbiter.sv
// rtl/xdma_desc_byp_arbiter.sv - round-robin share of one XDMA descriptor-bypass port
// Registered descriptor stage plus an in-order channel FIFO that routes desc_done back to its issuer.
module xdma_desc_byp_arbiter #(
  parameter int NUM_CH          = 4,
  parameter int ADDR_W          = 64,
  parameter int LEN_W           = 28,
  parameter int CTL_W           = 16,
  parameter int MAX_OUTSTANDING = 8,
  parameter int IDX_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic [NUM_CH-1:0]        req_valid,
  output logic [NUM_CH-1:0]        req_ready,
  input  logic [NUM_CH*ADDR_W-1:0] req_src_addr,
  input  logic [NUM_CH*ADDR_W-1:0] req_dst_addr,
  input  logic [NUM_CH*LEN_W-1:0]  req_len,
  input  logic [NUM_CH*CTL_W-1:0]  req_ctl,
  output logic [NUM_CH-1:0]        ch_done,
  input  logic                     byp_ready,
  output logic                     byp_load,
  output logic [ADDR_W-1:0]        byp_src_addr,
  output logic [ADDR_W-1:0]        byp_dst_addr,
  output logic [LEN_W-1:0]         byp_len,
  output logic [CTL_W-1:0]         byp_ctl,
  input  logic                     desc_done,
  output logic [CNT_W-1:0]         outstanding,
  output logic                     err_spurious_done
);

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_src;
  logic [ADDR_W-1:0]   r_dst;
  logic [LEN_W-1:0]    r_len;
  logic [CTL_W-1:0]    r_ctl;
  logic [IDX_W-1:0]    r_held_idx;
  logic [IDX_W-1:0]    r_rr_ptr;
  logic [IDX_W-1:0]    r_fifo [MAX_OUTSTANDING];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [CNT_W-1:0]    r_count;
  logic [NUM_CH-1:0]   r_ch_done;
  logic                r_err;

  logic                w_push;
  logic                w_pop;
  logic [CNT_W:0]      w_occ_if_push;
  logic                w_can_accept;
  logic                w_gnt_any;
  logic [IDX_W-1:0]    w_gnt_idx;
  logic [IDX_W:0]      w_scan;
  logic                w_grant;
  logic [IDX_W-1:0]    w_rr_nxt;

  assign w_push = (r_state == ISSUE) && byp_ready;
  assign w_pop  = desc_done && (r_count != '0);

  // Held descriptor counts against the budget so FIFO plus output stage never exceeds MAX_OUTSTANDING.
  assign w_occ_if_push = {1'b0, r_count} + (CNT_W+1)'(r_state == ISSUE) - (CNT_W+1)'(w_pop);
  assign w_can_accept  = ((r_state == IDLE) || byp_ready) &&
                         (w_occ_if_push < (CNT_W+1)'(MAX_OUTSTANDING));

  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    w_scan    = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_scan = {1'b0, r_rr_ptr} + (IDX_W+1)'(k);
      if (w_scan >= (IDX_W+1)'(NUM_CH)) begin
        w_scan = w_scan - (IDX_W+1)'(NUM_CH);
      end
      if (!w_gnt_any && req_valid[w_scan[IDX_W-1:0]]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = w_scan[IDX_W-1:0];
      end
    end
  end

  assign w_grant  = w_can_accept && w_gnt_any;
  assign w_rr_nxt = (w_gnt_idx == IDX_W'(NUM_CH - 1)) ? '0 : w_gnt_idx + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    if (w_grant) begin
      req_ready[w_gnt_idx] = 1'b1;
      w_state_nxt          = ISSUE;
    end else if (w_push) begin
      w_state_nxt = IDLE;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_src      <= '0;
      r_dst      <= '0;
      r_len      <= '0;
      r_ctl      <= '0;
      r_held_idx <= '0;
      r_rr_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_ch_done  <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_grant) begin
        r_src      <= req_src_addr[w_gnt_idx*ADDR_W +: ADDR_W];
        r_dst      <= req_dst_addr[w_gnt_idx*ADDR_W +: ADDR_W];
        r_len      <= req_len[w_gnt_idx*LEN_W +: LEN_W];
        r_ctl      <= req_ctl[w_gnt_idx*CTL_W +: CTL_W];
        r_held_idx <= w_gnt_idx;
        r_rr_ptr   <= w_rr_nxt;
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count   <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      r_ch_done <= '0;
      if (w_pop) begin
        r_ch_done[r_fifo[r_rd_ptr]] <= 1'b1;
      end
      if (desc_done && (r_count == '0)) begin
        r_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= r_held_idx;
    end
  end

  assign byp_load          = (r_state == ISSUE);
  assign byp_src_addr      = r_src;
  assign byp_dst_addr      = r_dst;
  assign byp_len           = r_len;
  assign byp_ctl           = r_ctl;
  assign ch_done           = r_ch_done;
  assign outstanding       = r_count;
  assign err_spurious_done = r_err;

endmodule

// File: tb/tb_xdma_desc_byp_arbiter.sv
// tb/tb_xdma_desc_byp_arbiter.sv - directed self-checking bench for xdma_desc_byp_arbiter
// Inputs change 1ns after the rising edge; comb outputs are read 1ns later, registered ones 1ns after the edge.
module tb_xdma_desc_byp_arbiter;

  localparam int NUM_CH  = 4;
  localparam int ADDR_W  = 64;
  localparam int LEN_W   = 28;
  localparam int CTL_W   = 16;
  localparam int MAX_OUT = 8;
  localparam int CNT_W   = 4;

  logic                     CLK = 1'b0;
  logic                     RST_N;
  logic [NUM_CH-1:0]        req_valid;
  logic [NUM_CH-1:0]        req_ready;
  logic [NUM_CH*ADDR_W-1:0] req_src_addr;
  logic [NUM_CH*ADDR_W-1:0] req_dst_addr;
  logic [NUM_CH*LEN_W-1:0]  req_len;
  logic [NUM_CH*CTL_W-1:0]  req_ctl;
  logic [NUM_CH-1:0]        ch_done;
  logic                     byp_ready;
  logic                     byp_load;
  logic [ADDR_W-1:0]        byp_src_addr;
  logic [ADDR_W-1:0]        byp_dst_addr;
  logic [LEN_W-1:0]         byp_len;
  logic [CTL_W-1:0]         byp_ctl;
  logic                     desc_done;
  logic [CNT_W-1:0]         outstanding;
  logic                     err_spurious_done;

  int checks   = 0;
  int failures = 0;

  xdma_desc_byp_arbiter #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .CTL_W(CTL_W), .MAX_OUTSTANDING(MAX_OUT)
  ) dut (
    .CLK(CLK), .RST_N(RST_N),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_src_addr(req_src_addr), .req_dst_addr(req_dst_addr),
    .req_len(req_len), .req_ctl(req_ctl),
    .ch_done(ch_done),
    .byp_ready(byp_ready), .byp_load(byp_load),
    .byp_src_addr(byp_src_addr), .byp_dst_addr(byp_dst_addr),
    .byp_len(byp_len), .byp_ctl(byp_ctl),
    .desc_done(desc_done), .outstanding(outstanding),
    .err_spurious_done(err_spurious_done)
  );

  always #5 CLK = ~CLK;

  function automatic logic [ADDR_W-1:0] exp_src(input int ch);
    return ADDR_W'(ch + 1) * 64'h1000;
  endfunction

  function automatic logic [ADDR_W-1:0] exp_dst(input int ch);
    return ADDR_W'(ch + 1) * 64'h2000;
  endfunction

  function automatic logic [LEN_W-1:0] exp_len(input int ch);
    return LEN_W'(64 * (ch + 1));
  endfunction

  function automatic logic [NUM_CH-1:0] onehot(input int ch);
    logic [NUM_CH-1:0] v;
    v = '0;
    v[ch] = 1'b1;
    return v;
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset();
    RST_N     = 1'b0;
    req_valid = '0;
    byp_ready = 1'b0;
    desc_done = 1'b0;
    step();
    step();
    RST_N = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    checks++;
    if (byp_load !== 1'b0 || byp_src_addr !== '0 || byp_len !== '0) begin
      failures++;
      $display("FAIL reset_byp: load=%b src=%h len=%h expected 0/0/0", byp_load, byp_src_addr, byp_len);
    end
    checks++;
    if (ch_done !== '0 || outstanding !== '0 || err_spurious_done !== 1'b0 || req_ready !== '0) begin
      failures++;
      $display("FAIL reset_status: ch_done=%b outstanding=%0d err=%b req_ready=%b expected all 0",
               ch_done, outstanding, err_spurious_done, req_ready);
    end
  endtask

  task automatic test_single();
    apply_reset();
    req_valid = 4'b0001;
    byp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL single_grant: req_ready=%b expected 0001", req_ready);
    end
    step();
    req_valid = '0;
    checks++;
    if (byp_load !== 1'b1 || byp_src_addr !== 64'h1000 || byp_dst_addr !== 64'h2000 ||
        byp_len !== 28'd64 || outstanding !== 4'd0) begin
      failures++;
      $display("FAIL single_issue: load=%b src=%h dst=%h len=%0d out=%0d expected 1/1000/2000/64/0",
               byp_load, byp_src_addr, byp_dst_addr, byp_len, outstanding);
    end
    step();
    checks++;
    if (byp_load !== 1'b0 || outstanding !== 4'd1) begin
      failures++;
      $display("FAIL single_push: load=%b outstanding=%0d expected 0/1", byp_load, outstanding);
    end
    step();
    step();
    step();
    desc_done = 1'b1;
    step();
    desc_done = 1'b0;
    checks++;
    if (ch_done !== 4'b0001 || outstanding !== 4'd0) begin
      failures++;
      $display("FAIL single_done: ch_done=%b outstanding=%0d expected 0001/0", ch_done, outstanding);
    end
    step();
    checks++;
    if (ch_done !== 4'b0000) begin
      failures++;
      $display("FAIL single_done_pulse: ch_done=%b expected 0000", ch_done);
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    req_valid = 4'b1111;
    byp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      checks++;
      if (req_ready !== onehot(k % NUM_CH)) begin
        failures++;
        $display("FAIL rr_grant[%0d]: req_ready=%b expected %b", k, req_ready, onehot(k % NUM_CH));
      end
      step();
      checks++;
      if (byp_src_addr !== exp_src(k % NUM_CH) || byp_len !== exp_len(k % NUM_CH)) begin
        failures++;
        $display("FAIL rr_payload[%0d]: src=%h len=%0d expected %h/%0d", k, byp_src_addr, byp_len,
                 exp_src(k % NUM_CH), exp_len(k % NUM_CH));
      end
    end
    req_valid = '0;
    step();
    checks++;
    if (outstanding !== 4'd8) begin
      failures++;
      $display("FAIL rr_outstanding: outstanding=%0d expected 8", outstanding);
    end
    for (int k = 0; k < 8; k++) begin
      desc_done = 1'b1;
      step();
      checks++;
      if (ch_done !== onehot(k % NUM_CH)) begin
        failures++;
        $display("FAIL rr_done[%0d]: ch_done=%b expected %b", k, ch_done, onehot(k % NUM_CH));
      end
    end
    desc_done = 1'b0;
    step();
    checks++;
    if (ch_done !== '0 || outstanding !== 4'd0) begin
      failures++;
      $display("FAIL rr_drained: ch_done=%b outstanding=%0d expected 0/0", ch_done, outstanding);
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    byp_ready = 1'b0;
    req_valid = 4'b0001;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL bp_first_grant: req_ready=%b expected 0001", req_ready);
    end
    step();
    req_valid = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (req_ready !== 4'b0000) begin
        failures++;
        $display("FAIL bp_no_ready[%0d]: req_ready=%b expected 0000", k, req_ready);
      end
      step();
      checks++;
      if (byp_load !== 1'b1 || byp_src_addr !== exp_src(0) || byp_dst_addr !== exp_dst(0) ||
          byp_len !== exp_len(0) || outstanding !== 4'd0) begin
        failures++;
        $display("FAIL bp_stable[%0d]: load=%b src=%h dst=%h len=%0d out=%0d", k, byp_load,
                 byp_src_addr, byp_dst_addr, byp_len, outstanding);
      end
    end
    byp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      failures++;
      $display("FAIL bp_release_grant: req_ready=%b expected 0010", req_ready);
    end
    step();
    req_valid = '0;
    checks++;
    if (outstanding !== 4'd1 || byp_load !== 1'b1 || byp_src_addr !== exp_src(1)) begin
      failures++;
      $display("FAIL bp_release: out=%0d load=%b src=%h expected 1/1/%h", outstanding, byp_load,
               byp_src_addr, exp_src(1));
    end
    step();
    checks++;
    if (outstanding !== 4'd2 || byp_load !== 1'b0) begin
      failures++;
      $display("FAIL bp_idle: out=%0d load=%b expected 2/0", outstanding, byp_load);
    end
  endtask

  task automatic test_full();
    apply_reset();
    req_valid = 4'b1111;
    byp_ready = 1'b1;
    for (int k = 0; k < MAX_OUT; k++) begin
      #1;
      checks++;
      if (req_ready !== onehot(k % NUM_CH)) begin
        failures++;
        $display("FAIL full_grant[%0d]: req_ready=%b expected %b", k, req_ready, onehot(k % NUM_CH));
      end
      step();
    end
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin
      failures++;
      $display("FAIL full_block_issue: req_ready=%b expected 0000", req_ready);
    end
    step();
    checks++;
    if (outstanding !== 4'd8 || byp_load !== 1'b0) begin
      failures++;
      $display("FAIL full_count: outstanding=%0d load=%b expected 8/0", outstanding, byp_load);
    end
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin
      failures++;
      $display("FAIL full_block_idle: req_ready=%b expected 0000", req_ready);
    end
    step();
    desc_done = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL full_unblock: req_ready=%b expected 0001", req_ready);
    end
    step();
    desc_done = 1'b0;
    req_valid = '0;
    checks++;
    if (ch_done !== 4'b0001 || outstanding !== 4'd7 || byp_load !== 1'b1 || byp_src_addr !== exp_src(0)) begin
      failures++;
      $display("FAIL full_after_pop: ch_done=%b out=%0d load=%b src=%h expected 0001/7/1/%h",
               ch_done, outstanding, byp_load, byp_src_addr, exp_src(0));
    end
    step();
    checks++;
    if (outstanding !== 4'd8) begin
      failures++;
      $display("FAIL full_refill: outstanding=%0d expected 8", outstanding);
    end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    byp_ready = 1'b1;
    req_valid = 4'b0111;
    step();
    step();
    step();
    req_valid = 4'b1000;
    step();
    checks++;
    if (outstanding !== 4'd3 || byp_src_addr !== exp_src(3)) begin
      failures++;
      $display("FAIL simul_setup: outstanding=%0d src=%h expected 3/%h", outstanding, byp_src_addr, exp_src(3));
    end
    req_valid = '0;
    desc_done = 1'b1;
    step();
    desc_done = 1'b0;
    checks++;
    if (outstanding !== 4'd3 || ch_done !== 4'b0001) begin
      failures++;
      $display("FAIL simul_push_pop: outstanding=%0d ch_done=%b expected 3/0001", outstanding, ch_done);
    end
  endtask

  task automatic test_spurious();
    apply_reset();
    desc_done = 1'b1;
    step();
    desc_done = 1'b0;
    checks++;
    if (err_spurious_done !== 1'b1 || ch_done !== '0 || outstanding !== '0) begin
      failures++;
      $display("FAIL spurious_flag: err=%b ch_done=%b outstanding=%0d expected 1/0000/0",
               err_spurious_done, ch_done, outstanding);
    end
    step();
    step();
    step();
    checks++;
    if (err_spurious_done !== 1'b1) begin
      failures++;
      $display("FAIL spurious_sticky: err=%b expected 1", err_spurious_done);
    end
  endtask

  task automatic test_async_reset();
    byp_ready = 1'b0;
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    checks++;
    if (byp_load !== 1'b1) begin
      failures++;
      $display("FAIL areset_setup: load=%b expected 1", byp_load);
    end
    #2;
    RST_N = 1'b0;
    #1;
    checks++;
    if (byp_load !== 1'b0 || byp_src_addr !== '0 || outstanding !== '0 ||
        err_spurious_done !== 1'b0 || ch_done !== '0) begin
      failures++;
      $display("FAIL areset_clear: load=%b src=%h out=%0d err=%b ch_done=%b expected all 0",
               byp_load, byp_src_addr, outstanding, err_spurious_done, ch_done);
    end
    step();
    RST_N     = 1'b1;
    req_valid = 4'b1111;
    byp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL areset_rr_ptr: req_ready=%b expected 0001", req_ready);
    end
    step();
    req_valid = '0;
  endtask

  initial begin
    RST_N     = 1'b0;
    req_valid = '0;
    byp_ready = 1'b0;
    desc_done = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      req_src_addr[i*ADDR_W +: ADDR_W] = exp_src(i);
      req_dst_addr[i*ADDR_W +: ADDR_W] = exp_dst(i);
      req_len[i*LEN_W +: LEN_W]        = exp_len(i);
      req_ctl[i*CTL_W +: CTL_W]        = CTL_W'(i + 1);
    end
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_full();
    test_simultaneous();
    test_spurious();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
